// File: rtl/bnn_conv_engine.sv
`default_nettype none
// ============================================================================
// Module   : bnn_conv_engine
// Binary 3x3 convolution over a 28x28 image, 8 kernels in parallel, one
// thresholded beat per cycle behind a ready/valid output register.
// Macro BNN_CONV_SAME_PAD_EN selects same padding (28x28 output) instead of
// valid convolution (26x26 output).
// Revision : 1.0
// ============================================================================
module bnn_conv_engine (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [27:0][27:0]      pixels,
    input  logic [2:0][2:0]        weights [0:7],
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [7:0]             out_bits,
    output logic [4:0]             out_row,
    output logic [4:0]             out_col,
    output logic                   busy,
    output logic                   done
);

`ifdef BNN_CONV_SAME_PAD_EN
    localparam logic [4:0] c_last = 5'd27;
`else
    localparam logic [4:0] c_last = 5'd25;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] row_q, row_d;
    logic [4:0] col_q, col_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_bits_q, out_bits_d;
    logic [4:0] out_row_q, out_row_d;
    logic [4:0] out_col_q, out_col_d;
    logic       done_q, done_d;

    logic [2:0][2:0] w_win;
    logic [7:0]      w_hit;
    logic            w_load;

    function automatic logic [3:0] popcount9(input logic [8:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 9; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    generate
        for (genvar r = 0; r < 3; r++) begin : g_row
            for (genvar c = 0; c < 3; c++) begin : g_col
`ifdef BNN_CONV_SAME_PAD_EN
                // Window coordinates are offset by +1; 0 and 29 lie outside the image.
                logic [5:0] w_pr;
                logic [5:0] w_pc;
                assign w_pr = {1'b0, row_q} + 6'(r);
                assign w_pc = {1'b0, col_q} + 6'(c);
                assign w_win[r][c] = ((w_pr != 6'd0) && (w_pr <= 6'd28) &&
                                      (w_pc != 6'd0) && (w_pc <= 6'd28))
                                   ? pixels[5'(w_pr - 6'd1)][5'(w_pc - 6'd1)]
                                   : 1'b0;
`else
                assign w_win[r][c] = pixels[row_q + 5'(r)][col_q + 5'(c)];
`endif
            end
        end

        for (genvar k = 0; k < 8; k++) begin : g_kern
            assign w_hit[k] = (popcount9(~(w_win ^ weights[k])) >= 4'd5);
        end
    endgenerate

    assign w_load = !out_valid_q || out_ready;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        out_valid_d = out_valid_q;
        out_bits_d  = out_bits_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    row_d   = 5'd0;
                    col_d   = 5'd0;
                end
            end
            RUN: begin
                if (w_load) begin
                    out_valid_d = 1'b1;
                    out_bits_d  = w_hit;
                    out_row_d   = row_q;
                    out_col_d   = col_q;
                    if (row_q == c_last && col_q == c_last) begin
                        state_d = DRAIN;
                    end else if (col_q == c_last) begin
                        col_d = 5'd0;
                        row_d = row_q + 5'd1;
                    end else begin
                        col_d = col_q + 5'd1;
                    end
                end
            end
            DRAIN: begin
                // The last beat is still registered; wait for it to be taken.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            row_q       <= 5'd0;
            col_q       <= 5'd0;
            out_valid_q <= 1'b0;
            out_bits_q  <= 8'd0;
            out_row_q   <= 5'd0;
            out_col_q   <= 5'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            out_valid_q <= out_valid_d;
            out_bits_q  <= out_bits_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            done_q      <= done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_bits  = out_bits_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bnn_conv_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_bnn_conv_engine
// Scoreboard bench for bnn_conv_engine: a reference convolution model fills
// the expected queue, received beats are collected and compared in order.
// Revision : 1.0
// ============================================================================
module tb_bnn_conv_engine;

`ifdef BNN_CONV_SAME_PAD_EN
    localparam int c_n   = 28;
    localparam int c_off = 1;
`else
    localparam int c_n   = 26;
    localparam int c_off = 0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              out_ready = 1'b1;
    logic [27:0][27:0] pixels;
    logic [2:0][2:0]   weights [0:7];
    logic              out_valid;
    logic [7:0]        out_bits;
    logic [4:0]        out_row;
    logic [4:0]        out_col;
    logic              busy;
    logic              done;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [17:0] exp_q[$];
    logic [17:0] got_q[$];

    int first_valid_cyc;
    int done_cnt;
    bit done_next;
    bit held_ok;
    bit timed_out;

    bnn_conv_engine dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pixels    (pixels),
        .weights   (weights),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_bits  (out_bits),
        .out_row   (out_row),
        .out_col   (out_col),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model(input int row, input int col);
        logic [7:0] res;
        int         cnt;
        int         pr;
        int         pc;
        logic       p;
        res = 8'd0;
        for (int k = 0; k < 8; k++) begin
            cnt = 0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    pr = row + r - c_off;
                    pc = col + c - c_off;
                    p  = (pr >= 0 && pr < 28 && pc >= 0 && pc < 28) ? pixels[pr][pc] : 1'b0;
                    if (p == weights[k][r][c]) cnt++;
                end
            end
            res[k] = (cnt >= 5);
        end
        return res;
    endfunction

    task automatic push_expected();
        exp_q.delete();
        for (int row = 0; row < c_n; row++) begin
            for (int col = 0; col < c_n; col++) begin
                exp_q.push_back({5'(row), 5'(col), model(row, col)});
            end
        end
    endtask

    task automatic fill_random();
        for (int r = 0; r < 28; r++) pixels[r] = 28'($urandom);
        for (int k = 0; k < 8; k++) weights[k] = 9'($urandom);
    endtask

    // Runs one pass from a start pulse; entered and left at #1 after a rising edge.
    task automatic run_pass(input int max_beats, input int stall_at,
                            input int stall_len, input bit rand_ready);
        int          beat;
        int          cyc;
        int          stall_cnt;
        int          last_acc;
        logic [17:0] held;
        beat = 0; cyc = 0; stall_cnt = 0; last_acc = -1; held = '0;
        got_q.delete();
        first_valid_cyc = -1; done_cnt = 0; done_next = 1'b0;
        held_ok = 1'b1; timed_out = 1'b0;
        start = 1'b1;
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (done) done_cnt++;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (last_acc >= 0 && cyc == last_acc + 1) done_next = done && !out_valid;
            if (last_acc >= 0 && cyc == last_acc + 3) break;
            if (beat < max_beats) begin
                if (out_valid && beat == stall_at && stall_cnt < stall_len) begin
                    if (stall_cnt == 0) held = {out_row, out_col, out_bits};
                    else if ({out_row, out_col, out_bits} !== held) held_ok = 1'b0;
                    stall_cnt++;
                    out_ready = 1'b0;
                end else begin
                    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (out_valid && out_ready) begin
                    got_q.push_back({out_row, out_col, out_bits});
                    beat++;
                    if (beat == c_n * c_n) last_acc = cyc;
                    else if (beat == max_beats) break;
                end
            end
            if (cyc > c_n * c_n * 3 + 100) begin
                timed_out = 1'b1;
                break;
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({out_valid, out_bits, out_row, out_col, busy, done} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_initial: got %h expected 0",
                     {out_valid, out_bits, out_row, out_col, busy, done});
        end
        fill_random();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL busy_after_start: got %b expected 1", busy);
        end
        repeat (4) @(posedge clk);
        #3;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL valid_before_reset: got %b expected 1", out_valid);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, out_bits, out_row, out_col, busy, done} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected 0",
                     {out_valid, out_bits, out_row, out_col, busy, done});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, out_valid} !== 3'b000) begin
            n_fail++; $display("FAIL idle_after_reset: got %b expected 000", {busy, done, out_valid});
        end
    endtask

    task automatic test_all_ones();
        logic [17:0] e, g;
        pixels = '1;
        for (int k = 0; k < 8; k++) weights[k] = '1;
        push_expected();
        run_pass(c_n * c_n, -1, 0, 1'b0);
        n_cmp++;
        if (timed_out) begin n_fail++; $display("FAIL ones_timeout: got 1 expected 0"); end
        n_cmp++;
        if (first_valid_cyc != 2) begin
            n_fail++; $display("FAIL ones_latency: got %0d expected 2", first_valid_cyc);
        end
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL ones_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end
`ifndef BNN_CONV_SAME_PAD_EN
        n_cmp++;
        if (got_q.size() > 0 && got_q[0][7:0] !== 8'hFF) begin
            n_fail++; $display("FAIL ones_bits_const: got %h expected ff", got_q[0][7:0]);
        end
`endif
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_fail++; $display("FAIL ones_beat: got %h expected %h", g, e); end
        end
        n_cmp++;
        if (done_cnt != 1 || !done_next) begin
            n_fail++; $display("FAIL ones_done: got cnt=%0d next=%b expected cnt=1 next=1", done_cnt, done_next);
        end
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ones_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_zero_weights();
        logic [17:0] e, g;
        pixels = '1;
        for (int k = 0; k < 8; k++) weights[k] = '0;
        push_expected();
        run_pass(c_n * c_n, -1, 0, 1'b0);
        n_cmp++;
        if (got_q.size() != exp_q.size() || timed_out) begin
            n_fail++; $display("FAIL zero_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_fail++; $display("FAIL zero_beat: got %h expected %h", g, e); end
        end
        n_cmp++;
        if (done_cnt != 1 || !done_next) begin
            n_fail++; $display("FAIL zero_done: got cnt=%0d next=%b expected cnt=1 next=1", done_cnt, done_next);
        end
    endtask

    task automatic test_checkerboard();
        logic [17:0] e, g;
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++) pixels[r][c] = 1'((r + c) % 2);
        for (int k = 0; k < 8; k++) weights[k] = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) weights[0][r][c] = 1'((r + c) % 2);
        push_expected();
        run_pass(c_n * c_n, -1, 0, 1'b0);
        n_cmp++;
        if (got_q.size() != exp_q.size() || timed_out) begin
            n_fail++; $display("FAIL checker_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_fail++; $display("FAIL checker_beat: got %h expected %h", g, e); end
        end
    endtask

    task automatic test_backpressure();
        logic [17:0] e, g;
        fill_random();
        push_expected();
        run_pass(c_n * c_n, 100, 10, 1'b0);
        n_cmp++;
        if (!held_ok) begin n_fail++; $display("FAIL stall_hold: got 0 expected 1"); end
        n_cmp++;
        if (got_q.size() != exp_q.size() || timed_out) begin
            n_fail++; $display("FAIL stall_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_fail++; $display("FAIL stall_beat: got %h expected %h", g, e); end
        end
        n_cmp++;
        if (done_cnt != 1 || !done_next) begin
            n_fail++; $display("FAIL stall_done: got cnt=%0d next=%b expected cnt=1 next=1", done_cnt, done_next);
        end
    endtask

    task automatic test_random_ready();
        logic [17:0] e, g;
        fill_random();
        push_expected();
        run_pass(c_n * c_n, -1, 0, 1'b1);
        n_cmp++;
        if (got_q.size() != exp_q.size() || timed_out) begin
            n_fail++; $display("FAIL rready_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_fail++; $display("FAIL rready_beat: got %h expected %h", g, e); end
        end
        n_cmp++;
        if (done_cnt != 1 || !done_next) begin
            n_fail++; $display("FAIL rready_done: got cnt=%0d next=%b expected cnt=1 next=1", done_cnt, done_next);
        end
    endtask

    task automatic test_reset_midpass();
        logic [17:0] e, g;
        int          dn;
        fill_random();
        push_expected();
        run_pass(300, -1, 0, 1'b0);
        n_cmp++;
        if (got_q.size() != 300) begin
            n_fail++; $display("FAIL abort_count: got %0d expected 300", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_fail++; $display("FAIL abort_beat: got %h expected %h", g, e); end
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        n_cmp++;
        if (dn != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_done: got done=%0d busy=%b expected 0 0", dn, busy);
        end
        push_expected();
        run_pass(c_n * c_n, -1, 0, 1'b0);
        n_cmp++;
        if (got_q.size() == 0 || got_q[0][17:8] !== 10'd0) begin
            n_fail++; $display("FAIL restart_origin: got %h expected 000", got_q.size() ? got_q[0][17:8] : 10'h3FF);
        end
        n_cmp++;
        if (got_q.size() != exp_q.size() || timed_out) begin
            n_fail++; $display("FAIL restart_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_fail++; $display("FAIL restart_beat: got %h expected %h", g, e); end
        end
        n_cmp++;
        if (done_cnt != 1 || !done_next) begin
            n_fail++; $display("FAIL restart_done: got cnt=%0d next=%b expected cnt=1 next=1", done_cnt, done_next);
        end
    endtask

    initial begin
        pixels = '0;
        for (int k = 0; k < 8; k++) weights[k] = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_all_ones();
        test_zero_weights();
        test_checkerboard();
        test_backpressure();
        test_random_ready();
        test_reset_midpass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
